// File: rtl/delay_sched.sv
// rtl/delay_sched.sv - single-bit delay line with inertial FSM and optional transport queue
// Build option: define TRANSPORT_EN to add the transport queue, timestamp and mode input.
module delay_sched #(
  parameter int DW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a,
  input  logic [DW-1:0] dly,
  input  logic          mode,
  output logic          y,
  output logic          busy,
  output logic          ovf
);
  typedef enum logic {IDLE, PEND} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d, dly_q, dly_raw, dly_eff;
  logic          y_q, y_d, y_i;
  logic          mode_eff, q_nonempty;

  // dly (and mode) are frozen while anything is in flight
  assign dly_raw = busy ? dly_q : dly;
  assign dly_eff = (dly_raw == '0) ? DW'(1) : dly_raw;
  assign busy    = (state_q == PEND) || q_nonempty;
  assign y       = y_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_i     = y_q;
    if (!mode_eff) begin
      if (state_q == IDLE) begin
        if (a != y_q) begin
          if (dly_eff == DW'(1)) begin
            y_i = a;
          end else begin
            state_d = PEND;
            cnt_d   = dly_eff - DW'(1);
          end
        end
      end else if (a == y_q) begin
        state_d = IDLE;
      end else if (cnt_q == DW'(1)) begin
        y_i     = a;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      if (!busy) dly_q <= dly;
    end
  end

`ifdef TRANSPORT_EN
  localparam int AW = $clog2(DEPTH);

  logic [DW:0]   ts_q, due_new, late;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic          mode_q, lp_q, lp_d, ovf_q, ovf_d, push, pop, y_t, q_full;
  logic          val_mem [DEPTH];
  logic [DW:0]   due_mem [DEPTH];

  assign mode_eff   = busy ? mode_q : mode;
  assign q_nonempty = (count_q != '0);
  assign q_full     = (count_q == (AW+1)'(DEPTH));
  assign due_new    = ts_q + (DW+1)'(dly_eff) - (DW+1)'(1);
  // head is due once ts has reached it; outstanding entries are never more than 2^DW ahead
  assign late       = ts_q - due_mem[rd_q];
  assign y_d        = mode_eff ? y_t : y_i;
  assign ovf        = ovf_q;

  always_comb begin
    push  = 1'b0;
    pop   = 1'b0;
    y_t   = y_q;
    lp_d  = lp_q;
    ovf_d = ovf_q;
    if (mode_eff) begin
      if (q_nonempty && !late[DW]) begin
        pop = 1'b1;
        y_t = val_mem[rd_q];
      end
      if (a != lp_q) begin
        if (!q_nonempty && dly_eff == DW'(1)) begin
          y_t  = a;
          lp_d = a;
        end else if (!q_full) begin
          push = 1'b1;
          lp_d = a;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end else begin
      lp_d = y_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q    <= '0;
      lp_q    <= 1'b0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      ts_q    <= ts_q + (DW+1)'(1);
      lp_q    <= lp_d;
      ovf_q   <= ovf_d;
      if (!busy) mode_q <= mode;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      val_mem[wr_q] <= a;
      due_mem[wr_q] <= due_new;
    end
  end
`else
  localparam int unused_depth = DEPTH;
  logic unused_mode;

  assign unused_mode = mode;
  assign mode_eff    = 1'b0;
  assign q_nonempty  = 1'b0;
  assign y_d         = y_i;
  assign ovf         = 1'b0;
`endif
endmodule

// File: tb/tb_delay_sched.sv
// tb/tb_delay_sched.sv - randomized and directed check of delay_sched against a cycle-time reference model
module tb_delay_sched;
  localparam int DW    = 4;
  localparam int DEPTH = 4;

  logic          clk, rst, a, mode;
  logic [DW-1:0] dly;
  logic          y, busy, ovf;

  int checks   = 0;
  int failures = 0;

  delay_sched #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .a(a), .dly(dly), .mode(mode),
    .y(y), .busy(busy), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference: inertial = count consecutive edges where a differs from y;
  // transport = list of (value, absolute due cycle)
  typedef struct { bit v; int due; } ent_t;
  ent_t mq[$];
  bit   m_y, m_lp, m_ovf, m_mode;
  int   m_run, m_d, n;

  function automatic bit m_busy();
    return (m_run > 0) || (mq.size() > 0);
  endfunction

  function automatic void model_edge(bit r, bit ai, int di, bit mi);
    int sz;
    if (r) begin
      m_y = 0; m_lp = 0; m_ovf = 0; m_run = 0; n = 0;
      mq.delete();
      return;
    end
    if (!m_busy()) begin
      m_d    = (di == 0) ? 1 : di;
      m_mode = mi;
    end
`ifndef TRANSPORT_EN
    m_mode = 0;
`endif
    if (m_mode) begin
      sz = mq.size();
      if (sz > 0 && mq[0].due == n) begin
        m_y = mq[0].v;
        void'(mq.pop_front());
      end
      if (ai != m_lp) begin
        if (sz == 0 && m_d == 1) begin
          m_y = ai; m_lp = ai;
        end else if (sz < DEPTH) begin
          mq.push_back('{v: ai, due: n + m_d - 1});
          m_lp = ai;
        end else begin
          m_ovf = 1;
        end
      end
      m_run = 0;
    end else begin
      if (ai != m_y) begin
        m_run++;
        if (m_run >= m_d) begin
          m_y   = ai;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_lp = m_y;
    end
    n++;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit ai, input int di, input bit mi);
    @(negedge clk);
    rst = r; a = ai; dly = DW'(di); mode = mi;
    @(posedge clk);
    model_edge(r, ai, di, mi);
    #1;
    check("y", {31'd0, y}, {31'd0, m_y});
    check("busy", {31'd0, busy}, {31'd0, m_busy()});
    check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  task automatic hold(input int cycles, input bit ai, input int di, input bit mi);
    for (int i = 0; i < cycles; i++) step(1'b0, ai, di, mi);
  endtask

  initial begin
    int  len, dv;
    bit  av, mv;
    rst = 1'b1; a = 1'b0; dly = '0; mode = 1'b0;
    step(1'b1, 0, 0, 0);
    step(1'b1, 0, 0, 0);
    check("reset_y", {31'd0, y}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // inertial dly=3: long high level
    hold(5, 0, 3, 0); hold(15, 1, 3, 0); hold(10, 0, 3, 0);
    // inertial dly=3: pulse and gap filtered, then 7-cycle level
    hold(1, 1, 3, 0); hold(1, 0, 3, 0); hold(7, 1, 3, 0); hold(8, 0, 3, 0);
    // dly=0 behaves as dly=1
    hold(1, 1, 0, 0); hold(1, 0, 0, 0); hold(3, 1, 0, 0); hold(3, 0, 0, 0);

    // reset while pending with cnt=2
    hold(2, 0, 3, 0);
    hold(1, 1, 3, 0);
    step(1'b1, 1, 3, 0);
    check("rst_pend_y", {31'd0, y}, 32'd0);
    check("rst_pend_busy", {31'd0, busy}, 32'd0);
    hold(8, 0, 3, 0);
    check("rst_pend_quiet", {31'd0, y}, 32'd0);

`ifdef TRANSPORT_EN
    // transport dly=3: 1-cycle pulses preserved
    hold(3, 0, 3, 1);
    hold(1, 1, 3, 1); hold(1, 0, 3, 1); hold(1, 1, 3, 1); hold(1, 0, 3, 1);
    hold(8, 0, 3, 1);
    check("tr_pulse_ovf", {31'd0, ovf}, 32'd0);
    // transport dly=15, queue overflow from 6 toggles
    for (int i = 0; i < 6; i++) step(1'b0, (i % 2 == 0), 15, 1);
    check("tr_ovf_set", {31'd0, ovf}, 32'd1);
    hold(40, 0, 15, 1);
    check("tr_final_y", {31'd0, y}, 32'd0);
    check("tr_ovf_sticky", {31'd0, ovf}, 32'd1);
    step(1'b1, 0, 0, 0);
    check("tr_ovf_cleared", {31'd0, ovf}, 32'd0);
`endif

    // randomized: held levels of varied length, occasional resets
    av = 0;
    for (int k = 0; k < 1200; k++) begin
      len = $urandom_range(1, 8);
      dv  = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 6);
      mv  = $urandom_range(0, 1);
      av  = ~av;
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 399) == 0) step(1'b1, av, dv, mv);
        else step(1'b0, av, dv, mv);
        if ($urandom_range(0, 3) == 0) dv = $urandom_range(0, 15);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
